// File: rtl/decode_pkg.sv
// Shared constants for the decode-stage scoreboard.
// Register-file geometry and default pending-write counter width.
package decode_pkg;

    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W_DEF = 2;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter.
// Ports: clk, rstn, inc (issue), dec (writeback), clr (flush),
//        cnt (current count), err (writeback seen with count at zero).
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    // An underflowing writeback is flagged but the count holds at zero.
    // A flush overrides everything, including the error.
    always_comb begin
        err = dec & ~inc & ~clr & (cnt == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc & ~dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec & ~inc & (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode issue/stall controller: tracks in-flight GPR writes and holds decode on hazards.
// Ports: decode handshake (dec_valid/dec_ready), operand indices, execute handshake
//        (ex_ready/ex_valid), writeback (rd_wb_index/rd_we), flush,
//        status busy_mask, sticky sb_err, saturating stall_cycles.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int PERF_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [REG_IDX_W-1:0] rj_index,
    input  logic                 rj_used,
    input  logic [REG_IDX_W-1:0] rk_index,
    input  logic                 rk_used,
    input  logic [REG_IDX_W-1:0] rd_index,
    input  logic                 rd_write,
    input  logic                 ex_ready,
    output logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] rd_wb_index,
    input  logic                 rd_we,
    input  logic                 flush,
    output logic [REG_NUM-1:0]   busy_mask,
    output logic                 sb_err,
    output logic [PERF_W-1:0]    stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   cnt [REG_NUM];
    logic [REG_NUM-1:0] err_vec;
    logic               rj_haz;
    logic               rk_haz;
    logic               rd_haz;
    logic               haz;
    logic               issue;

    // r0 is hard-wired: never busy, never in error.
    assign cnt[0]       = '0;
    assign err_vec[0]   = 1'b0;
    assign busy_mask[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue & rd_write & (rd_index == REG_IDX_W'(r));
        assign dec = rd_we & (rd_wb_index == REG_IDX_W'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk  (clk),
            .rstn (rstn),
            .inc  (inc),
            .dec  (dec),
            .clr  (flush),
            .cnt  (cnt[r]),
            .err  (err_vec[r])
        );

        assign busy_mask[r] = (cnt[r] != '0);
    end

    // Hazards look only at registered counts: a writeback in the same
    // cycle does not release a waiting reader until the next cycle.
    always_comb begin
        rj_haz = rj_used & (rj_index != ZERO_REG) & (cnt[rj_index] != '0);
        rk_haz = rk_used & (rk_index != ZERO_REG) & (cnt[rk_index] != '0);
        rd_haz = rd_write & (rd_index != ZERO_REG) & (cnt[rd_index] == CNT_MAX);
        haz    = rj_haz | rk_haz | rd_haz;
    end

    // Nothing issues while reset is held.
    assign dec_ready = ~haz & ex_ready & ~flush & rstn;
    assign issue     = dec_valid & dec_ready;
    assign ex_valid  = issue;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_err <= 1'b0;
        end else if (|err_vec) begin
            sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (dec_valid & ex_ready & haz & ~flush & ~(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard.
// Directed hazard scenarios followed by randomized traffic against a reference model.
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [4:0]  rj_index = '0;
    logic        rj_used = 1'b0;
    logic [4:0]  rk_index = '0;
    logic        rk_used = 1'b0;
    logic [4:0]  rd_index = '0;
    logic        rd_write = 1'b0;
    logic        ex_ready = 1'b0;
    logic        ex_valid;
    logic [4:0]  rd_wb_index = '0;
    logic        rd_we = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] busy_mask;
    logic        sb_err;
    logic [31:0] stall_cycles;

    int          n_vec = 0;
    int          n_err = 0;

    // Reference state: number of outstanding writes per register.
    int          m_cnt [32];
    bit          m_err;
    logic [31:0] m_stall;

    localparam int MAXC = 3;

    always #5 clk = ~clk;

    decode_scoreboard dut (
        .clk          (clk),
        .rstn         (rstn),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .rj_index     (rj_index),
        .rj_used      (rj_used),
        .rk_index     (rk_index),
        .rk_used      (rk_used),
        .rd_index     (rd_index),
        .rd_write     (rd_write),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .rd_wb_index  (rd_wb_index),
        .rd_we        (rd_we),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .sb_err       (sb_err),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err   = 1'b0;
        m_stall = '0;
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) b[r] = 1'b1;
        return b;
    endfunction

    task automatic step(input logic dv,
                        input logic rju, input logic [4:0] rj,
                        input logic rku, input logic [4:0] rk,
                        input logic rdw, input logic [4:0] rd,
                        input logic exr,
                        input logic we, input logic [4:0] wb,
                        input logic fl);
        bit haz, rdy, iss, inc, dec;
        dec_valid   = dv;
        rj_used     = rju;
        rj_index    = rj;
        rk_used     = rku;
        rk_index    = rk;
        rd_write    = rdw;
        rd_index    = rd;
        ex_ready    = exr;
        rd_we       = we;
        rd_wb_index = wb;
        flush       = fl;
        #1;
        haz = (rju && rj != 0 && m_cnt[rj] != 0) ||
              (rku && rk != 0 && m_cnt[rk] != 0) ||
              (rdw && rd != 0 && m_cnt[rd] == MAXC);
        rdy = !haz && exr && !fl;
        iss = dv && rdy;
        chk("dec_ready", dec_ready, rdy);
        chk("ex_valid", ex_valid, iss);
        chk("busy_mask", busy_mask, m_busy());
        chk("sb_err", sb_err, m_err);
        chk("stall_cycles", stall_cycles, m_stall);
        @(posedge clk);
        if (dv && exr && haz && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (fl) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                inc = iss && rdw && rd == r;
                dec = we && wb == r;
                if (inc && !dec) m_cnt[r]++;
                else if (dec && !inc) begin
                    if (m_cnt[r] > 0) m_cnt[r]--;
                    else m_err = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        step(1, 0, 0, 0, 0, 1, rd, 1, 0, 0, 0);
    endtask

    task automatic read_rj(input logic [4:0] rj);
        step(1, 1, rj, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic wb_only(input logic [4:0] wb);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, wb, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        logic [4:0] rj, rk, rd, wb;
        logic       we;
        model_reset();

        // Reset: nothing busy, no issue even with a valid request.
        dec_valid = 1'b1;
        ex_ready  = 1'b1;
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall", stall_cycles, 0);
        dec_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        idle();

        // RAW on r5: held until the cycle after its writeback.
        issue_rd(5);
        read_rj(5);
        read_rj(5);
        step(1, 1, 5, 0, 0, 0, 0, 1, 1, 5, 0);
        read_rj(5);
        idle();

        // rk operand hazard.
        issue_rd(6);
        step(1, 0, 0, 1, 6, 0, 0, 1, 0, 0, 0);
        wb_only(6);
        step(1, 0, 0, 1, 6, 0, 0, 1, 0, 0, 0);

        // Counter full on r7: fourth write waits for one writeback.
        issue_rd(7);
        issue_rd(7);
        issue_rd(7);
        issue_rd(7);
        step(1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0);
        issue_rd(7);
        wb_only(7);
        wb_only(7);
        wb_only(7);
        idle();

        // Simultaneous issue and writeback on r9 leaves the count unchanged.
        issue_rd(9);
        step(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0);
        idle();
        wb_only(9);
        idle();

        // r0 is never tracked.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        wb_only(0);
        idle();

        // Flush clears all counts and swallows the same-cycle writeback.
        issue_rd(3);
        issue_rd(3);
        issue_rd(4);
        step(1, 0, 0, 0, 0, 1, 6, 1, 1, 3, 1);
        idle();

        // Underflow sets the sticky error.
        wb_only(12);
        idle();
        idle();

        // Ten counted hazard cycles; ex_ready=0 and flush cycles are not counted.
        issue_rd(20);
        for (int i = 0; i < 10; i++) read_rj(20);
        step(1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 20, 0, 0, 0, 0, 1, 0, 0, 1);
        idle();

        // Randomized traffic on a small register window to force hazards.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                dec_valid = 1'b1;
                ex_ready  = 1'b1;
                rstn      = 1'b0;
                #1;
                model_reset();
                chk("midrst_ex_valid", ex_valid, 0);
                chk("midrst_busy", busy_mask, 0);
                chk("midrst_sb_err", sb_err, 0);
                chk("midrst_stall", stall_cycles, 0);
                @(negedge clk);
                rstn = 1'b1;
                #1;
            end
            rj = 5'($urandom_range(0, 7));
            rk = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            wb = 5'($urandom_range(1, 7));
            we = (m_cnt[wb] != 0) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 63) == 0) begin
                we = 1'b1;
                wb = 5'($urandom_range(0, 31));
            end
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), rj,
                 1'($urandom_range(0, 1)), rk,
                 1'($urandom_range(0, 1)), rd,
                 1'($urandom_range(0, 5) != 0),
                 we, wb,
                 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
